sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 27 ++
 rtl/sram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and widths for the audio SRAM arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS, DONE)
//   op_t    : operation type latched at grant (WR = recorder, RD = player)
//   ADDR_W  : SRAM word address width
//   DATA_W  : SRAM data width
//   CNT_W   : width of the access-cycle counter (ACC_CYC legal range 1..15)
// -----------------------------------------------------------------------------
package sram_arb_pkg;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } op_t;

endpackage : sram_arb_pkg

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Arbitrates a recorder write port and a player read port onto a single
// asynchronous 16-bit SRAM. One access at a time; simultaneous requests are
// served round-robin. Each access holds the SRAM strobes for ACC_CYC cycles,
// followed by one DONE cycle that returns the ack/valid pulse.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wr_req/addr/data   write request (held until o_wr_ack)
//   o_wr_ack             one-cycle pulse, write completed
//   i_rd_req/addr        read request (held until o_rd_valid)
//   o_rd_data            read data, held until the next read completes
//   o_rd_valid           one-cycle pulse, o_rd_data updated
//   o_busy               high whenever the FSM is not IDLE
//   o_SRAM_*, io_SRAM_DQ SRAM device pins (CE/LB/UB tied active)
// -----------------------------------------------------------------------------
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ACC_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,

   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,

   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,

   output logic              o_busy,

   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N
);

   // Counter value loaded at grant; ACCESS ends when it reaches zero.
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_CYC - 1);

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   op_t                last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               grant;

   logic [DATA_W-1:0]  wdata_q;
   logic               dq_oe_q;
   logic               we_n_q;
   logic               oe_n_q;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_RD;
         last_q  <= OP_RD;   // first contest after reset goes to the writer
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d = state_q;
      op_d    = op_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_wr_req && i_rd_req) begin
               grant = 1'b1;
               op_d  = (last_q == OP_WR) ? OP_RD : OP_WR;
            end else if (i_wr_req) begin
               grant = 1'b1;
               op_d  = OP_WR;
            end else if (i_rd_req) begin
               grant = 1'b1;
               op_d  = OP_RD;
            end

            if (grant) begin
               state_d = ST_ACCESS;
               last_d  = op_d;
               cnt_d   = CNT_INIT;
            end
         end

         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath and registered pin drivers
   // Strobes, DQ enable and the ack/valid pulses are decoded from the next
   // state and registered, so the SRAM pins never glitch while state and op
   // change together on the grant edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_SRAM_ADDR <= '0;
         wdata_q     <= '0;
         o_rd_data   <= '0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
         o_wr_ack    <= 1'b0;
         o_rd_valid  <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples the pre-edge values regardless of statement order.
         if (grant) begin
            o_SRAM_ADDR <= (op_d == OP_WR) ? i_wr_addr : i_rd_addr;
            wdata_q     <= i_wr_data;
         end

         // Capture read data on the edge that leaves ACCESS, while OE_N is
         // still low at the device.
         if (state_q == ST_ACCESS && cnt_q == '0 && op_q == OP_RD) begin
            o_rd_data <= io_SRAM_DQ;
         end

         we_n_q     <= !(state_d == ST_ACCESS && op_d == OP_WR);
         oe_n_q     <= !(state_d == ST_ACCESS && op_d == OP_RD);
         // Write data stays on the bus through DONE to cover SRAM hold time.
         dq_oe_q    <= (state_d != ST_IDLE) && (op_d == OP_WR);
         o_wr_ack   <= (state_d == ST_DONE) && (op_d == OP_WR);
         o_rd_valid <= (state_d == ST_DONE) && (op_d == OP_RD);
         o_busy     <= (state_d != ST_IDLE);
      end
   end

   assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
   assign o_SRAM_WE_N = we_n_q;
   assign o_SRAM_OE_N = oe_n_q;

   // Full 16-bit word accesses only.
   assign o_SRAM_CE_N = 1'b0;
   assign o_SRAM_LB_N = 1'b0;
   assign o_SRAM_UB_N = 1'b0;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed bench for sram_arbiter. A small SRAM model sits on the main
// instance's bus; two extra instances cover the ACC_CYC range limits.
// Cycle 0 is the IDLE cycle in which a request is first presented; inputs are
// driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   logic        clk;
   logic        rst;

   // Main instance (ACC_CYC = 2)
   logic        wr_req, rd_req;
   logic [19:0] wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic        wr_ack, rd_valid, busy;
   logic [15:0] rd_data;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n;

   // ACC_CYC = 1 instance
   logic        wr_req_a1, rd_req_a1, ack_a1, valid_a1, busy_a1;
   logic        we_a1, oe_a1, ce_a1, lb_a1, ub_a1;
   logic [15:0] rd_data_a1;
   logic [19:0] addr_a1;
   wire  [15:0] dq_a1;

   // ACC_CYC = 15 instance
   logic        wr_req_a15, rd_req_a15, ack_a15, valid_a15, busy_a15;
   logic        we_a15, oe_a15, ce_a15, lb_a15, ub_a15;
   logic [15:0] rd_data_a15;
   logic [19:0] addr_a15;
   wire  [15:0] dq_a15;

   int n_checks;
   int n_pass;

   // Released bus floats high, so "hi-Z" reads as 16'hFFFF; test data avoids it.
   localparam logic [15:0] BUS_IDLE = 16'hFFFF;

   for (genvar i = 0; i < 16; i++) begin : g_pull
      pullup pu (sram_dq[i]);
   end

   // ---------------------------------------------------------------------------
   // SRAM model (256 words, low address bits) with a preload port
   // ---------------------------------------------------------------------------
   logic [15:0] mem [0:255];
   logic        pre_en;
   logic [7:0]  pre_addr;
   logic [15:0] pre_data;

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
   end

   assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

   // ---------------------------------------------------------------------------
   // DUTs
   // ---------------------------------------------------------------------------
   sram_arbiter #(.ACC_CYC(2)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
      .o_busy(busy),
      .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
      .o_SRAM_WE_N(sram_we_n), .o_SRAM_CE_N(sram_ce_n), .o_SRAM_OE_N(sram_oe_n),
      .o_SRAM_LB_N(sram_lb_n), .o_SRAM_UB_N(sram_ub_n)
   );

   sram_arbiter #(.ACC_CYC(1)) u_dut_a1 (
      .i_clk(clk), .i_rst(rst),
      .i_wr_req(wr_req_a1), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(ack_a1),
      .i_rd_req(rd_req_a1), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a1), .o_rd_valid(valid_a1),
      .o_busy(busy_a1),
      .o_SRAM_ADDR(addr_a1), .io_SRAM_DQ(dq_a1),
      .o_SRAM_WE_N(we_a1), .o_SRAM_CE_N(ce_a1), .o_SRAM_OE_N(oe_a1),
      .o_SRAM_LB_N(lb_a1), .o_SRAM_UB_N(ub_a1)
   );

   sram_arbiter #(.ACC_CYC(15)) u_dut_a15 (
      .i_clk(clk), .i_rst(rst),
      .i_wr_req(wr_req_a15), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(ack_a15),
      .i_rd_req(rd_req_a15), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a15), .o_rd_valid(valid_a15),
      .o_busy(busy_a15),
      .o_SRAM_ADDR(addr_a15), .io_SRAM_DQ(dq_a15),
      .o_SRAM_WE_N(we_a15), .o_SRAM_CE_N(ce_a15), .o_SRAM_OE_N(oe_a15),
      .o_SRAM_LB_N(lb_a15), .o_SRAM_UB_N(ub_a15)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Advance to the falling edge of the next cycle.
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   int first1, first15, low1, low15, k;

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      wr_req     = 1'b0; rd_req     = 1'b0;
      wr_req_a1  = 1'b0; rd_req_a1  = 1'b0;
      wr_req_a15 = 1'b0; rd_req_a15 = 1'b0;
      wr_addr    = '0;   rd_addr    = '0;   wr_data = '0;
      pre_en     = 1'b0; pre_addr   = '0;   pre_data = '0;

      // Preload the model while reset is held.
      @(negedge clk);
      pre_en = 1'b1;
      pre_addr = 8'h20; pre_data = 16'h1234; next_cycle();
      for (int i = 0; i < 4; i++) begin
         pre_addr = 8'(i);
         pre_data = 16'(16'h1111 * (i + 1));
         next_cycle();
      end
      pre_en = 1'b0;

      // ---- Reset state ----
      check("rst_we_n",    {31'd0, sram_we_n}, 32'd1);
      check("rst_oe_n",    {31'd0, sram_oe_n}, 32'd1);
      check("rst_dq",      {16'd0, sram_dq},   {16'd0, BUS_IDLE});
      check("rst_addr",    {12'd0, sram_addr}, 32'd0);
      check("rst_rd_data", {16'd0, rd_data},   32'd0);
      check("rst_pulses",  {30'd0, wr_ack, rd_valid}, 32'd0);
      check("rst_busy",    {31'd0, busy},      32'd0);
      check("ce_lb_ub",    {26'd0, sram_ce_n, sram_lb_n, sram_ub_n, ce_a1, lb_a1, ub_a15}, 32'd0);
      rst = 1'b0;
      next_cycle();

      // ---- Single write: 0x00010 <- 0xA5A5 ----
      wr_addr = 20'h00010; wr_data = 16'hA5A5; wr_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         check($sformatf("wr_we_n_c%0d", c), {31'd0, sram_we_n}, {31'd0, c > 2});
         check($sformatf("wr_oe_n_c%0d", c), {31'd0, sram_oe_n}, 32'd1);
         check($sformatf("wr_dq_c%0d", c),   {16'd0, sram_dq},
               {16'd0, (c <= 3) ? 16'hA5A5 : BUS_IDLE});
         check($sformatf("wr_ack_c%0d", c),  {31'd0, wr_ack}, {31'd0, c == 3});
         check($sformatf("wr_busy_c%0d", c), {31'd0, busy},   {31'd0, c <= 3});
         if (c == 3) wr_req = 1'b0;
      end
      check("wr_addr_hold", {12'd0, sram_addr}, 32'h00010);

      // ---- Single read: 0x00020 holds 0x1234 ----
      rd_addr = 20'h00020; rd_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         check($sformatf("rd_oe_n_c%0d", c),  {31'd0, sram_oe_n}, {31'd0, c > 2});
         check($sformatf("rd_we_n_c%0d", c),  {31'd0, sram_we_n}, 32'd1);
         check($sformatf("rd_valid_c%0d", c), {31'd0, rd_valid},  {31'd0, c == 3});
         if (c >= 3) begin
            check($sformatf("rd_data_c%0d", c), {16'd0, rd_data}, 32'h1234);
            check($sformatf("rd_dq_c%0d", c),   {16'd0, sram_dq}, {16'd0, BUS_IDLE});
         end
         if (c == 3) rd_req = 1'b0;
      end

      // ---- Read back the earlier write ----
      rd_addr = 20'h00010; rd_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         if (c == 3) begin
            check("rdback_valid", {31'd0, rd_valid}, 32'd1);
            check("rdback_data",  {16'd0, rd_data},  32'hA5A5);
            rd_req = 1'b0;
         end
      end

      // ---- Contention after reset: WR, RD, WR, RD ----
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      check("cont_rst_rd_data", {16'd0, rd_data}, 32'd0);
      wr_addr = 20'h00030; wr_data = 16'hBEEF; wr_req = 1'b1;
      rd_addr = 20'h00020; rd_req = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         next_cycle();
         check($sformatf("cont_ack_c%0d", c),   {31'd0, wr_ack},   {31'd0, c == 3 || c == 11});
         check($sformatf("cont_valid_c%0d", c), {31'd0, rd_valid}, {31'd0, c == 7 || c == 15});
         check($sformatf("cont_busy_c%0d", c),  {31'd0, busy},     {31'd0, (c % 4) != 0});
         if (c == 1) check("cont_addr_c1", {12'd0, sram_addr}, 32'h00030);
         if (c == 5) check("cont_addr_c5", {12'd0, sram_addr}, 32'h00020);
         if (c == 7 || c == 15) check($sformatf("cont_data_c%0d", c), {16'd0, rd_data}, 32'h1234);
         if (c == 15) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
         end
      end

      // ---- Reset during write ACCESS cycle 1 ----
      wr_addr = 20'h00040; wr_data = 16'h5555; wr_req = 1'b1;
      next_cycle();
      check("abort_we_n_c1", {31'd0, sram_we_n}, 32'd0);
      rst = 1'b1; wr_req = 1'b0;
      next_cycle();
      rst = 1'b0;
      check("abort_we_n_c2", {31'd0, sram_we_n}, 32'd1);
      check("abort_dq_c2",   {16'd0, sram_dq},   {16'd0, BUS_IDLE});
      check("abort_busy_c2", {31'd0, busy},      32'd0);
      check("abort_ack_c2",  {31'd0, wr_ack},    32'd0);
      next_cycle();
      check("abort_ack_c3",  {31'd0, wr_ack},    32'd0);
      check("abort_busy_c3", {31'd0, busy},      32'd0);

      // ---- Back-to-back reads, addresses 0..3 ----
      k = 0;
      rd_addr = 20'd0; rd_req = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         next_cycle();
         check($sformatf("seq_valid_c%0d", c), {31'd0, rd_valid}, {31'd0, (c % 4) == 3});
         check($sformatf("seq_we_n_c%0d", c),  {31'd0, sram_we_n}, 32'd1);
         if (sram_oe_n) check($sformatf("seq_dq_c%0d", c), {16'd0, sram_dq}, {16'd0, BUS_IDLE});
         if (rd_valid) begin
            check($sformatf("seq_data_%0d", k), {16'd0, rd_data}, {16'd0, 16'(16'h1111 * (k + 1))});
            k++;
            rd_addr = 20'(k);
            if (k == 4) rd_req = 1'b0;
         end
      end
      check("seq_count", 32'(k), 32'd4);

      // ---- ACC_CYC limits: write then read on both extra instances ----
      wr_addr = 20'h00050; wr_data = 16'h0F0F; rd_addr = 20'h00055;
      first1 = 0; first15 = 0; low1 = 0; low15 = 0;
      wr_req_a1 = 1'b1; wr_req_a15 = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         next_cycle();
         if (!we_a1)  low1++;
         if (!we_a15) low15++;
         if (ack_a1 && first1 == 0)   begin first1 = c;  wr_req_a1 = 1'b0;  end
         if (ack_a15 && first15 == 0) begin first15 = c; wr_req_a15 = 1'b0; end
      end
      check("a1_ack_cycle",   32'(first1),  32'd2);
      check("a15_ack_cycle",  32'(first15), 32'd16);
      check("a1_we_width",    32'(low1),    32'd1);
      check("a15_we_width",   32'(low15),   32'd15);

      first1 = 0; first15 = 0; low1 = 0; low15 = 0;
      rd_req_a1 = 1'b1; rd_req_a15 = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         next_cycle();
         if (!oe_a1)  low1++;
         if (!oe_a15) low15++;
         if (valid_a1 && first1 == 0)   begin first1 = c;  rd_req_a1 = 1'b0;  end
         if (valid_a15 && first15 == 0) begin first15 = c; rd_req_a15 = 1'b0; end
      end
      check("a1_valid_cycle", 32'(first1),  32'd2);
      check("a15_valid_cycle",32'(first15), 32'd16);
      check("a1_oe_width",    32'(low1),    32'd1);
      check("a15_oe_width",   32'(low15),   32'd15);
      check("a_addr_hold",    {8'd0, addr_a1[11:0], addr_a15[11:0]}, 32'h0005_5055);
      check("a_idle",         {28'd0, busy_a1, busy_a15, lb_a15, ub_a1}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sram_arbiter
